// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder that steps one full-adder cell across
// WIDTH-bit operands, LSB first, one bit per clock.
// Optional build macro: SERIAL_ADD_SUB_EN adds a 'sub' port for A-B mode.
// Operand A's shift register also collects the sum bits at its MSB end, so
// after WIDTH steps it holds the finished result.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_load;
    logic             carry;
    logic             carry_init;
    logic [CW-1:0]    cnt;

    logic s1;
    logic c1;
    logic s;
    logic c2;
    logic carry_next;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is A + ~B + 1: invert B on entry and seed the carry with 1.
    assign b_load     = sub ? ~b_in : b_in;
    assign carry_init = sub;
`else
    assign b_load     = b_in;
    assign carry_init = 1'b0;
`endif

    // The shared full-adder cell: two half-adder stages and a carry OR.
    assign s1         = a_sh[0] ^ b_sh[0];
    assign c1         = a_sh[0] & b_sh[0];
    assign s          = s1 ^ carry;
    assign c2         = s1 & carry;
    assign carry_next = c1 | c2;

    // Shift the new sum bit into the top of A as its LSB is consumed.
    generate
        if (WIDTH == 1) begin : g_one_bit
            assign a_next = s;
        end else begin : g_multi_bit
            assign a_next = {s, a_sh[WIDTH-1:1]};
        end
    endgenerate

    // Sequencer: accept a start, step the cell WIDTH times, publish the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= RUN;
                        a_sh     <= a_in;
                        b_sh     <= b_load;
                        carry    <= carry_init;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        cout_out <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh  <= a_next;
                    b_sh  <= b_sh >> 1;
                    carry <= carry_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum_out  <= a_next;
                        cout_out <= carry_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed bench for serial_add_ctrl (WIDTH=8).
// Honours SERIAL_ADD_SUB_EN to connect and exercise the 'sub' port.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub),
`endif
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int n_done   = 0;

    // Reference model state: an arithmetic result plus edge counting since the start.
    bit               m_busy = 0;
    bit               m_done = 0;
    logic [WIDTH-1:0] m_sum  = '0;
    bit               m_cout = 0;
    int               m_cnt  = 0;
    logic [WIDTH:0]   m_res  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_done = 0; m_sum = '0; m_cout = 0; m_cnt = 0;
        end else if (!m_busy && start) begin
            if (sub)
                m_res = {1'b0, a_in} + {1'b0, ~b_in} + 1;
            else
                m_res = {1'b0, a_in} + {1'b0, b_in};
            m_busy = 1; m_done = 0; m_cout = 0; m_cnt = 1;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == WIDTH + 1) begin
                m_busy = 0; m_done = 1;
                m_sum  = m_res[WIDTH-1:0];
                m_cout = m_res[WIDTH];
            end
        end else begin
            m_done = 0;
        end
        @(negedge clk);
        cyc++;
        if (done) n_done++;
        check("busy",     32'(busy),     32'(m_busy));
        check("done",     32'(done),     32'(m_done));
        check("sum_out",  32'(sum_out),  32'(m_sum));
        check("cout_out", 32'(cout_out), 32'(m_cout));
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s, input logic st);
        a_in  = a;
        b_in  = b;
        sub   = s;
        start = st;
    endtask

    // Wait (bounded) for the done pulse and pin the result to hand-computed values.
    task automatic checkOutput(input string name, input logic [WIDTH-1:0] exp_sum,
                               input logic exp_cout, output int done_cyc);
        int k = 0;
        while (!done && k < 40) begin
            step();
            k++;
        end
        done_cyc = cyc;
        n_checks++;
        if (!done) begin
            n_fails++;
            $display("[TB] FAIL %s_timeout: no done within %0d cycles", name, k);
        end else begin
            check({name, "_sum"},  32'(sum_out),  32'(exp_sum));
            check({name, "_cout"}, 32'(cout_out), 32'(exp_cout));
        end
    endtask

    initial begin
        int e0;
        int d1;
        int d2;
        int nb;
        int nd;
        rst = 1'b1;
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        step();
        step();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum",  32'(sum_out), 32'd0);
        check("reset_cout", 32'(cout_out), 32'd0);
        rst = 1'b0;
        step();

        // 0x5A + 0x3C: latency and busy length.
        $display("[TB] basic add and latency");
        applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b1);
        step();
        e0 = cyc;
        start = 1'b0;
        nb = 1;
        while (!done && cyc - e0 < 40) begin
            step();
            if (busy) nb++;
        end
        check("busy_cycles", 32'(nb), 32'd8);
        check("start_to_done_edges", 32'(cyc - e0 + 1), 32'd9);
        check("add_5a_3c_sum",  32'(sum_out), 32'h96);
        check("add_5a_3c_cout", 32'(cout_out), 32'd0);
        step();

        // Overflow and wrap.
        $display("[TB] overflow cases");
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1);
        step();
        start = 1'b0;
        checkOutput("add_ff_01", 8'h00, 1'b1, d1);
        step();
        applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b1);
        step();
        start = 1'b0;
        checkOutput("add_ff_ff", 8'hFE, 1'b1, d1);
        step();

        // Start pulse during RUN must be ignored.
        $display("[TB] start during run");
        nd = n_done;
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b1);
        step();
        start = 1'b0;
        step();
        step();
        applyStimulus(8'hAA, 8'h55, 1'b0, 1'b1);
        step();
        start = 1'b0;
        checkOutput("ignore_start", 8'h46, 1'b0, d1);
        for (int i = 0; i < 3; i++) step();
        check("ignore_start_done_count", 32'(n_done - nd), 32'd1);

        // Reset mid-RUN discards the partial result.
        $display("[TB] reset during run");
        applyStimulus(8'h80, 8'h80, 1'b0, 1'b1);
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        nd = n_done;
        rst = 1'b1;
        step();
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_sum",  32'(sum_out), 32'd0);
        check("midrun_rst_cout", 32'(cout_out), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check("midrun_rst_no_done", 32'(n_done - nd), 32'd0);
        applyStimulus(8'h01, 8'h02, 1'b0, 1'b1);
        step();
        start = 1'b0;
        checkOutput("after_rst", 8'h03, 1'b0, d1);
        step();

        // Back-to-back with start held high.
        $display("[TB] back-to-back");
        applyStimulus(8'h10, 8'h20, 1'b0, 1'b1);
        step();
        a_in = 8'h0F;
        b_in = 8'h01;
        checkOutput("b2b_first", 8'h30, 1'b0, d1);
        step();
        start = 1'b0;
        check("b2b_rerun_busy", 32'(busy), 32'd1);
        checkOutput("b2b_second", 8'h10, 1'b0, d2);
        check("b2b_done_spacing", 32'(d2 - d1), 32'd9);
        step();

`ifdef SERIAL_ADD_SUB_EN
        // Subtraction mode.
        $display("[TB] subtract mode");
        applyStimulus(8'h10, 8'h01, 1'b1, 1'b1);
        step();
        start = 1'b0;
        checkOutput("sub_10_01", 8'h0F, 1'b1, d1);
        step();
        applyStimulus(8'h01, 8'h02, 1'b1, 1'b1);
        step();
        start = 1'b0;
        checkOutput("sub_01_02", 8'hFF, 1'b0, d1);
        step();
        sub = 1'b0;
`endif

        for (int i = 0; i < 3; i++) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add sequencer that time-shares one full-adder cell across two WIDTH-bit operands. The cell is two half-adder stages plus a carry OR. The block latches operands on a start request, steps the cell LSB-first once per clock while holding the running carry in a flop, and presents the assembled sum and carry-out with a one-cycle done pulse. It sits between a requesting controller and the adder primitives, replacing a WIDTH-wide ripple chain with one cell and a small FSM.

## Interface
- `WIDTH`, default 8: operand and sum width in bits, ≥1.
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request to begin an addition. Sampled only in IDLE or DONE.
- `a_in` input WIDTH: operand A, latched on the accepted start edge.
- `b_in` input WIDTH: operand B, latched on the accepted start edge.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse, high only in DONE.
- `sum_out` output WIDTH: result. Valid from DONE and held until the next accepted start.
- `cout_out` output 1: final carry. Valid and held with `sum_out`.
- `sub` input 1: present only with `SERIAL_ADD_SUB_EN`. Latched with the operands.

## Operation
- Reset values: state IDLE; `busy`=0, `done`=0, `sum_out`=0, `cout_out`=0; internal carry=0; bit counter=0.
- States:
  - **IDLE**: `start`=1 moves to RUN.
  - **RUN**: stays for exactly WIDTH cycles, then moves to DONE.
  - **DONE**: `start`=1 moves to RUN (back-to-back). Otherwise moves to IDLE.
- Accepted start:
  - Latch `a_in`/`b_in` into shift registers.
  - Clear the bit counter.
  - Load carry = 0.
  - Clear `cout_out`. `sum_out` keeps its old value until DONE.
- Each RUN cycle `i` (0..WIDTH-1):
  - Cell inputs: a = A[0], b = B[0], cin = carry.
  - First stage: s1 = a^b, c1 = a&b.
  - Second stage: s = s1^cin, c2 = s1&cin.
  - Carry update: carry ← c1|c2.
  - Shift s into the result register MSB end. Shift A and B right by one.
  - Counter increments. The last RUN cycle is counter = WIDTH-1.
- On entry to DONE: `sum_out` ← assembled result; `cout_out` ← final carry.
- Arithmetic is modulo 2^WIDTH. Overflow shows only on `cout_out`; the sum wraps.
- `start` while in RUN is ignored: no restart, no operand re-latch.
- `rst` asserted in any state, including mid-RUN:
  - Next edge returns to reset values.
  - The partial result is discarded and no `done` is produced.
- WIDTH=1: RUN lasts one cycle. Otherwise the behaviour is identical.

## Timing
- Edge E0 samples `start`=1 in IDLE or DONE.
- `busy`=1 from after E0 through after E(WIDTH-1).
- After E(WIDTH): `busy`=0, `done`=1, `sum_out`/`cout_out` valid.
- After E(WIDTH+1): `done`=0. State is RUN if `start` was high at E(WIDTH), otherwise IDLE.
- Start-to-done latency is WIDTH+1 edges. Throughput is one result per WIDTH+1 cycles with `start` held high.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SERIAL_ADD_SUB_EN` defined:
  - The `sub` port exists and is latched on the accepted start.
  - When the latched `sub`=1: B is inverted as it is latched, and the initial carry loads 1.
  - Result: `sum_out` = A−B mod 2^WIDTH, `cout_out`=1 means no borrow.
  - When `sub`=0: pure add.
- `SERIAL_ADD_SUB_EN` undefined:
  - No `sub` port.
  - Add only, initial carry always 0.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, start one cycle -> `busy` high 8 cycles; `done` 9 edges after the start edge; `sum_out`=0x96, `cout_out`=0.
- A=0xFF, B=0x01 -> `sum_out`=0x00, `cout_out`=1. Then A=0xFF, B=0xFF -> `sum_out`=0xFE, `cout_out`=1.
- Start 0x12+0x34. Pulse `start` with A=0xAA, B=0x55 during RUN cycle 3 -> ignored; `sum_out`=0x46, `cout_out`=0, exactly one `done`.
- Start 0x80+0x80, assert `rst` in RUN cycle 4 -> next edge `busy`=0, `sum_out`=0, `cout_out`=0, no `done`. A following 0x01+0x02 yields 0x03.
- `start` held high with operands 0x10+0x20 then 0x0F+0x01 -> `done` pulses 9 cycles apart; results 0x30 then 0x10. The second RUN begins directly from DONE.
- With `SERIAL_ADD_SUB_EN`, `sub`=1:
  - A=0x10, B=0x01 -> `sum_out`=0x0F, `cout_out`=1.
  - A=0x01, B=0x02 -> `sum_out`=0xFF, `cout_out`=0.
